serial_bus_arbiter: RTL and testbench

- Shares one memory-mapped serial device port between NREQ independent requesters, e.g. the CPU data port and a debug/loader master.
- Each requester issues single-beat read/write transactions through a req/ack handshake.
- The arbiter picks one requester round-robin, drives the device-side enable/rw/addr/wdata for exactly one clock, and captures read data.
- Out-of-window requests are rejected with an error flag and never reach the device.
- Sits between the masters and the serial device on the device's clock.

---
 rtl/serial_bus_arbiter_pkg.sv | 22 ++
 rtl/serial_bus_arbiter_rr_pick.sv | 32 +++
 rtl/serial_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_serial_bus_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_arbiter_pkg.sv
// Shared definitions for the serial device arbiter: FSM encoding, default
// device window, and the window test used at grant time.
package serial_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default word-address window of the serial device.
    localparam int unsigned DEV_BASE = 32;
    localparam int unsigned DEV_SIZE = 2;

    // Subtracting first keeps the upper bound safe against base+size wrapping.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/serial_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr,
// wrapping modulo NREQ.
module serial_bus_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   grant
);

    logic [IW:0] pos;

    // Walk from farthest to nearest so the candidate closest to ptr is the
    // last assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        pos   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ))
                pos = pos - (IW+1)'(NREQ);
            if (req[pos[IW-1:0]]) begin
                valid = 1'b1;
                grant = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one serial device port between NREQ
// single-beat masters. In-window accesses take IDLE->ISSUE->DONE (3 cycles);
// out-of-window accesses skip the device and error out via IDLE->DONE.
module serial_bus_arbiter
    import serial_bus_arbiter_pkg::*;
#(
    parameter int          NREQ = 2,
    parameter int unsigned BASE = DEV_BASE,
    parameter int unsigned SIZE = DEV_SIZE
) (
    input  logic               clk,
    input  logic               _reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_rw,
    input  logic [32*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [31:0]        rdata,
    output logic               dev_enable,
    output logic               dev_rw,
    output logic [31:0]        dev_addr,
    output logic [31:0]        dev_wdata,
    input  logic [31:0]        dev_rdata
);

    localparam int IW = $clog2(NREQ);
    localparam logic [31:0] BASE_W = 32'(BASE);
    localparam logic [31:0] SIZE_W = 32'(SIZE);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic            pick_valid;
    logic [IW-1:0]   pick_grant;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_rw;
    logic [NREQ-1:0] pick_onehot;
    logic [NREQ-1:0] gnt_onehot;

    serial_bus_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    // Mux the winner's payload and build one-hot acks for the current pick
    // and the latched grant.
    always_comb begin
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_rw      = 1'b0;
        pick_onehot = '0;
        gnt_onehot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant == IW'(i)) begin
                sel_addr       = req_addr[32*i +: 32];
                sel_wdata      = req_wdata[32*i +: 32];
                sel_rw         = req_rw[i];
                pick_onehot[i] = 1'b1;
            end
            if (gnt == IW'(i))
                gnt_onehot[i] = 1'b1;
        end
    end

    // Arbitration FSM with registered device strobe, ack and read data.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            ack        <= '0;
            err        <= 1'b0;
            rdata      <= '0;
            dev_enable <= 1'b0;
            dev_rw     <= 1'b0;
            dev_addr   <= '0;
            dev_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dev_enable <= 1'b0;
                    if (pick_valid) begin
                        gnt <= pick_grant;
                        if (in_window(sel_addr, BASE_W, SIZE_W)) begin
                            dev_rw     <= sel_rw;
                            dev_addr   <= sel_addr;
                            dev_wdata  <= sel_wdata;
                            dev_enable <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            // Rejected: the device is never touched.
                            ack   <= pick_onehot;
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (!dev_rw)
                        rdata <= dev_rdata;
                    dev_enable <= 1'b0;
                    ack        <= gnt_onehot;
                    err        <= 1'b0;
                    state      <= DONE;
                end
                DONE: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    // The requester just served drops to lowest priority.
                    ptr   <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter (NREQ=2, window 32..33) with a small
// negedge-sampling device model.
module tb_serial_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_rw;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic        dev_enable;
    logic        dev_rw;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;

    int checks = 0;
    int errors = 0;
    int en_count = 0;
    int wr_count = 0;
    int en_saved;
    logic [31:0] last_w = '0;

    serial_bus_arbiter #(.NREQ(2), .BASE(32), .SIZE(2)) dut (
        .clk        (clk),
        ._reset     (rst_n),
        .req        (req),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .dev_enable (dev_enable),
        .dev_rw     (dev_rw),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_rdata  (dev_rdata)
    );

    always #5 clk = ~clk;

    // Device model: acts on the negedge while enabled.
    always @(negedge clk) begin
        if (dev_enable) begin
            en_count = en_count + 1;
            if (dev_rw) begin
                wr_count = wr_count + 1;
                last_w   = dev_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0; dev_rdata = '0;
        #12;
        chk("rst_ack",  32'(ack), 32'h0);
        chk("rst_err",  32'(err), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_en",   32'(dev_enable), 32'h0);
        chk("rst_addr", dev_addr, 32'h0);
        rst_n = 1'b1;
        step();

        // single write from requester 0
        req = 2'b01; req_rw = 2'b01; req_addr[31:0] = 32'd32; req_wdata[31:0] = 32'h41;
        step();
        chk("wr_en",   32'(dev_enable), 32'h1);
        chk("wr_addr", dev_addr, 32'd32);
        chk("wr_data", dev_wdata, 32'h41);
        chk("wr_rw",   32'(dev_rw), 32'h1);
        chk("wr_ack_early", 32'(ack), 32'h0);
        step();
        chk("wr_en_off", 32'(dev_enable), 32'h0);
        chk("wr_ack",    32'(ack), 32'h1);
        chk("wr_err",    32'(err), 32'h0);
        req = '0;
        step();
        chk("wr_ack_off", 32'(ack), 32'h0);
        chk("wr_cnt",  32'(wr_count), 32'd1);
        chk("wr_char", last_w, 32'h41);

        // single read from requester 1
        req = 2'b10; req_rw = 2'b00; req_addr[63:32] = 32'd33; dev_rdata = 32'h5A;
        step();
        chk("rd_en",   32'(dev_enable), 32'h1);
        chk("rd_addr", dev_addr, 32'd33);
        chk("rd_rw",   32'(dev_rw), 32'h0);
        step();
        chk("rd_ack",  32'(ack), 32'h2);
        chk("rd_data", rdata, 32'h5A);
        req = '0; dev_rdata = '0;
        step();
        chk("rd_ack_off", 32'(ack), 32'h0);
        chk("rd_hold", rdata, 32'h5A);

        // contention, ptr=0: grants 0,1,0,1 every third cycle
        req = 2'b11; req_rw = 2'b11;
        req_addr  = {32'd33, 32'd32};
        req_wdata = {32'h20, 32'h10};
        for (int c = 0; c < 12; c++) begin
            logic [1:0] ea;
            step();
            ea = (c % 3 == 1) ? ((c % 6 == 1) ? 2'b01 : 2'b10) : 2'b00;
            chk($sformatf("cont_en%0d", c), 32'(dev_enable), (c % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("cont_ack%0d", c), 32'(ack), 32'(ea));
            if (c % 3 == 0)
                chk($sformatf("cont_addr%0d", c), dev_addr, (c % 6 == 0) ? 32'd32 : 32'd33);
        end
        req = '0;
        chk("cont_wr", 32'(wr_count), 32'd5);
        en_saved = en_count;

        // out-of-window above and below
        req = 2'b01; req_rw = 2'b01; req_addr[31:0] = 32'd34;
        step();
        chk("oow_hi_ack", 32'(ack), 32'h1);
        chk("oow_hi_err", 32'(err), 32'h1);
        chk("oow_hi_en",  32'(dev_enable), 32'h0);
        req = '0;
        step();
        chk("oow_hi_off", 32'(ack), 32'h0);
        chk("oow_hi_erroff", 32'(err), 32'h0);
        req = 2'b10; req_rw = 2'b00; req_addr[63:32] = 32'd31;
        step();
        chk("oow_lo_ack", 32'(ack), 32'h2);
        chk("oow_lo_err", 32'(err), 32'h1);
        chk("oow_lo_en",  32'(dev_enable), 32'h0);
        req = '0;
        step();
        chk("oow_lo_off", 32'(ack), 32'h0);
        chk("oow_no_dev", 32'(en_count), 32'(en_saved));

        // reset in the middle of an ISSUE cycle; ptr must return to 0
        req = 2'b01; req_rw = 2'b00; req_addr[31:0] = 32'd32; dev_rdata = 32'h33;
        step();
        step();
        chk("pre_ack", 32'(ack), 32'h1);
        chk("pre_rdata", rdata, 32'h33);
        req = '0;
        step();
        req = 2'b10; req_addr[63:32] = 32'd33;
        step();
        chk("mid_en", 32'(dev_enable), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en",    32'(dev_enable), 32'h0);
        chk("arst_ack",   32'(ack), 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        req = 2'b11; req_rw = 2'b01; req_addr = {32'd33, 32'd32}; req_wdata[31:0] = 32'h55;
        #3 rst_n = 1'b1;
        step();
        chk("post_en",   32'(dev_enable), 32'h1);
        chk("post_addr", dev_addr, 32'd32);
        chk("post_data", dev_wdata, 32'h55);
        chk("post_ack0", 32'(ack), 32'h0);
        step();
        chk("post_ack", 32'(ack), 32'h1);
        req = '0;
        step();

        // request dropped after grant still completes
        req = 2'b10; req_rw = 2'b10; req_addr[63:32] = 32'd33; req_wdata[63:32] = 32'h62;
        step();
        chk("drop_data", dev_wdata, 32'h62);
        req = '0;
        step();
        chk("drop_ack", 32'(ack), 32'h2);
        step();
        chk("drop_char", last_w, 32'h62);

        // payload stability: requester 1 changes while 0 is in ISSUE
        req = 2'b11; req_rw = 2'b11;
        req_addr = {32'd33, 32'd32}; req_wdata = {32'h62, 32'h61};
        step();
        chk("stab_addr0", dev_addr, 32'd32);
        chk("stab_data0", dev_wdata, 32'h61);
        req_addr[63:32] = 32'd32; req_wdata[63:32] = 32'h77;
        #5;
        chk("stab_hold", dev_wdata, 32'h61);
        req_addr[63:32] = 32'd33; req_wdata[63:32] = 32'h63;
        step();
        chk("stab_ack0", 32'(ack), 32'h1);
        chk("stab_char0", last_w, 32'h61);
        req = 2'b10;
        step();
        step();
        chk("stab_en1",   32'(dev_enable), 32'h1);
        chk("stab_addr1", dev_addr, 32'd33);
        chk("stab_data1", dev_wdata, 32'h63);
        step();
        chk("stab_ack1", 32'(ack), 32'h2);
        req = '0;
        step();
        chk("final_wr",   32'(wr_count), 32'd9);
        chk("final_char", last_w, 32'h63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
